mem_arbiter: RTL and testbench

Sequential arbiter that shares the single main-memory port between the instruction-cache refill engine and the data-cache refill/writeback engine. It serialises whole-block bursts, generates per-beat addresses, and routes read data and write-data beat indices back to the owning cache. It sits between both caches and the memory model. Its `ic_grant_o` is the source of the instruction-cache replacement-active condition consumed by the hazard unit.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refill/writeback bursts onto one memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D-cache wins ties.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  localparam int BW         = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  ic_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_grant_o,
  output logic                  ic_rvalid_o,
  output logic                  ic_done_o,
  input  logic                  dc_req_i,
  input  logic                  dc_we_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [DATA_WIDTH-1:0] dc_wdata_i,
  output logic                  dc_grant_o,
  output logic                  dc_rvalid_o,
  output logic                  dc_done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [BW-1:0]         beat_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BLOCK_WORDS - 1);

  state_e                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    we_q, we_d;
  logic                    ownerDc_q, ownerDc_d;
  logic                    dcWins;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                    lastDc_q, lastDc_d;

  // Reset value "last served I-cache" hands the very first tie to the D-cache.
  always_ff @(posedge clk_i) begin
    if (reset_i) lastDc_q <= 1'b0;
    else         lastDc_q <= lastDc_d;
  end

  assign dcWins = dc_req_i & (~ic_req_i | ~lastDc_q);
`else
  assign dcWins = dc_req_i;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      ownerDc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      we_q      <= we_d;
      ownerDc_q <= ownerDc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    we_d      = we_q;
    ownerDc_d = ownerDc_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    lastDc_d  = lastDc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dcWins) begin
          state_d   = DC_XFER;
          base_d    = dc_addr_i;
          we_d      = dc_we_i;
          ownerDc_d = 1'b1;
          beat_d    = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          lastDc_d  = 1'b1;
`endif
        end else if (ic_req_i) begin
          state_d   = IC_XFER;
          base_d    = ic_addr_i;
          we_d      = 1'b0;
          ownerDc_d = 1'b0;
          beat_d    = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          lastDc_d  = 1'b0;
`endif
        end
      end
      IC_XFER, DC_XFER: begin
        // The beat counter wraps to zero on the final beat, leaving it clean for DONE.
        if (mem_ready_i) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ic_grant_o  = (state_q == IC_XFER);
    dc_grant_o  = (state_q == DC_XFER);
    mem_req_o   = ic_grant_o | dc_grant_o;
    mem_we_o    = mem_req_o & we_q;
    mem_addr_o  = mem_req_o ? (base_q + ADDR_WIDTH'(beat_q) * STRIDE) : '0;
    mem_wdata_o = (dc_grant_o & we_q) ? dc_wdata_i : '0;
    ic_rvalid_o = ic_grant_o & mem_ready_i;
    dc_rvalid_o = dc_grant_o & ~we_q & mem_ready_i;
    ic_done_o   = (state_q == DONE) & ~ownerDc_q;
    dc_done_o   = (state_q == DONE) & ownerDc_q;
    rdata_o     = mem_rdata_i;
    beat_o      = beat_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for single bursts plus
// hand-written sequences for ties, held requests, address wrap and mid-burst reset.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ic_req_i, dc_req_i, dc_we_i, mem_ready_i;
  logic [31:0] ic_addr_i, dc_addr_i, dc_wdata_i, mem_rdata_i;
  logic        ic_grant_o, ic_rvalid_o, ic_done_o;
  logic        dc_grant_o, dc_rvalid_o, dc_done_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  beat_o;
  logic        mem_req_o, mem_we_o;

  int compared   = 0;
  int mismatched = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_grant_o(ic_grant_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_done_o(ic_done_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_grant_o(dc_grant_o), .dc_rvalid_o(dc_rvalid_o), .dc_done_o(dc_done_o),
    .rdata_o(rdata_o), .beat_o(beat_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Flag byte: {icGrant, icRvalid, icDone, dcGrant, dcRvalid, dcDone, memReq, memWe}
  localparam logic [7:0] F_IDLE  = 8'h00;
  localparam logic [7:0] F_ICRD  = 8'hC2;
  localparam logic [7:0] F_ICDN  = 8'h20;
  localparam logic [7:0] F_DCWR  = 8'h13;
  localparam logic [7:0] F_DCRD  = 8'h1A;
  localparam logic [7:0] F_DCDN  = 8'h04;

  typedef struct {
    logic        icReq, dcReq, dcWe, ready;
    logic [31:0] rdata, wdata;
    logic [7:0]  expFlags;
    logic [31:0] expAddr, expWdata;
    logic [1:0]  expBeat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] flags();
    return {ic_grant_o, ic_rvalid_o, ic_done_o, dc_grant_o, dc_rvalid_o, dc_done_o,
            mem_req_o, mem_we_o};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic icReq, input logic dcReq, input logic dcWe,
                        input logic ready, input logic [31:0] rdata, input logic [31:0] wdata,
                        input logic [7:0] ef, input logic [31:0] ea, input logic [31:0] ew,
                        input logic [1:0] eb);
    vec_t v;
    v.icReq = icReq; v.dcReq = dcReq; v.dcWe = dcWe; v.ready = ready;
    v.rdata = rdata; v.wdata = wdata; v.expFlags = ef; v.expAddr = ea;
    v.expWdata = ew; v.expBeat = eb;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    ic_req_i    = v.icReq;
    dc_req_i    = v.dcReq;
    dc_we_i     = v.dcWe;
    mem_ready_i = v.ready;
    mem_rdata_i = v.rdata;
    dc_wdata_i  = v.wdata;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    reset_i = 1'b1;
    ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0; mem_ready_i = 1'b0;
    mem_rdata_i = '0; dc_wdata_i = '0;
    @(negedge clk_i);
    #1;
    checkOutput("reset flags", {24'd0, flags()}, {24'd0, F_IDLE});
    checkOutput("reset addr", mem_addr_o, 32'd0);
    checkOutput("reset wdata", mem_wdata_o, 32'd0);
    checkOutput("reset beat", {30'd0, beat_o}, 32'd0);
    reset_i = 1'b0;
  endtask

  // One full read burst with ready held high, starting in the first granted cycle.
  task automatic runBurst(input string tag, input logic expDc, input logic [31:0] base,
                          input logic dropAtDone);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_i);
      mem_ready_i = 1'b1;
      mem_rdata_i = base ^ 32'(b * 32'h1111);
      #1;
      checkOutput({tag, " flags"}, {24'd0, flags()}, {24'd0, expDc ? F_DCRD : F_ICRD});
      checkOutput({tag, " addr"}, mem_addr_o, base + 32'(b * 4));
      checkOutput({tag, " beat"}, {30'd0, beat_o}, 32'(b));
      checkOutput({tag, " rdata"}, rdata_o, base ^ 32'(b * 32'h1111));
    end
    @(negedge clk_i);
    if (dropAtDone) begin
      if (expDc) dc_req_i = 1'b0;
      else       ic_req_i = 1'b0;
    end
    #1;
    checkOutput({tag, " done"}, {24'd0, flags()}, {24'd0, expDc ? F_DCDN : F_ICDN});
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk_i);
    #1;
    checkOutput(tag, {24'd0, flags()}, {24'd0, F_IDLE});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expSecondDc;
    reset_i = 1'b1;
    ic_req_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0; mem_ready_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0; mem_rdata_i = '0; dc_wdata_i = '0;

    // Lone I-cache refill at 0x100, then D-cache writeback at 0x200 with alternating stalls.
    addVec(1,0,0,1, 32'hA0, 0, F_IDLE, 32'h000, 0, 0);
    addVec(1,0,0,1, 32'hA1, 0, F_ICRD, 32'h100, 0, 0);
    addVec(1,0,0,1, 32'hA2, 0, F_ICRD, 32'h104, 0, 1);
    addVec(1,0,0,1, 32'hA3, 0, F_ICRD, 32'h108, 0, 2);
    addVec(1,0,0,1, 32'hA4, 0, F_ICRD, 32'h10C, 0, 3);
    addVec(0,0,0,1, 32'hA5, 0, F_ICDN, 32'h000, 0, 0);
    addVec(0,0,0,1, 32'hA6, 0, F_IDLE, 32'h000, 0, 0);
    addVec(0,1,1,0, 32'h50, 32'hD0, F_IDLE, 32'h000, 32'h00, 0);
    addVec(0,1,1,0, 32'h51, 32'hD1, F_DCWR, 32'h200, 32'hD1, 0);
    addVec(0,1,1,1, 32'h52, 32'hD2, F_DCWR, 32'h200, 32'hD2, 0);
    addVec(0,1,1,0, 32'h53, 32'hD3, F_DCWR, 32'h204, 32'hD3, 1);
    addVec(0,1,1,1, 32'h54, 32'hD4, F_DCWR, 32'h204, 32'hD4, 1);
    addVec(0,1,1,0, 32'h55, 32'hD5, F_DCWR, 32'h208, 32'hD5, 2);
    addVec(0,1,1,1, 32'h56, 32'hD6, F_DCWR, 32'h208, 32'hD6, 2);
    addVec(0,1,1,0, 32'h57, 32'hD7, F_DCWR, 32'h20C, 32'hD7, 3);
    addVec(0,1,1,1, 32'h58, 32'hD8, F_DCWR, 32'h20C, 32'hD8, 3);
    addVec(0,0,1,0, 32'h59, 32'hD9, F_DCDN, 32'h000, 32'h00, 0);
    addVec(0,0,0,0, 32'h5A, 32'hDA, F_IDLE, 32'h000, 32'h00, 0);

    doReset();
    ic_addr_i = 32'h100;
    dc_addr_i = 32'h200;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d flags", i), {24'd0, flags()}, {24'd0, vecs[i].expFlags});
      checkOutput($sformatf("vec%0d addr", i), mem_addr_o, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d wdata", i), mem_wdata_o, vecs[i].expWdata);
      checkOutput($sformatf("vec%0d beat", i), {30'd0, beat_o}, {30'd0, vecs[i].expBeat});
      checkOutput($sformatf("vec%0d rdata", i), rdata_o, vecs[i].rdata);
    end

    // Tie after reset: D-cache first, then the waiting I-cache after one IDLE cycle.
    doReset();
    ic_addr_i = 32'h300;
    dc_addr_i = 32'h400;
    @(negedge clk_i);
    ic_req_i = 1'b1; dc_req_i = 1'b1; dc_we_i = 1'b0;
    #1;
    checkOutput("tieA idle", {24'd0, flags()}, {24'd0, F_IDLE});
    runBurst("tieA dc", 1'b1, 32'h400, 1'b1);
    idleCheck("tieA gap");
    runBurst("tieA ic", 1'b0, 32'h300, 1'b1);
    idleCheck("tieA end");

    // Both requests held through done: two consecutive ties.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expSecondDc = 1'b0;
`else
    expSecondDc = 1'b1;
`endif
    doReset();
    @(negedge clk_i);
    ic_req_i = 1'b1; dc_req_i = 1'b1;
    #1;
    checkOutput("tieB idle", {24'd0, flags()}, {24'd0, F_IDLE});
    runBurst("tieB first", 1'b1, 32'h400, 1'b0);
    idleCheck("tieB gap1");
    runBurst("tieB second", expSecondDc, expSecondDc ? 32'h400 : 32'h300, 1'b1);
    idleCheck("tieB gap2");
    runBurst("tieB third", ~expSecondDc, expSecondDc ? 32'h300 : 32'h400, 1'b1);
    idleCheck("tieB end");

    // D-cache refill whose beat addresses wrap past the top of the address space.
    doReset();
    dc_addr_i = 32'hFFFF_FFF8;
    @(negedge clk_i);
    dc_req_i = 1'b1; dc_we_i = 1'b0;
    #1;
    checkOutput("wrap idle", {24'd0, flags()}, {24'd0, F_IDLE});
    runBurst("wrap", 1'b1, 32'hFFFF_FFF8, 1'b1);
    idleCheck("wrap end");

    // Reset at beat 2 aborts without a done pulse; a fresh request restarts at beat 0.
    doReset();
    ic_addr_i = 32'h500;
    @(negedge clk_i);
    ic_req_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    checkOutput("rst idle", {24'd0, flags()}, {24'd0, F_IDLE});
    for (int b = 0; b < 3; b++) begin
      @(negedge clk_i);
      ic_req_i = 1'b0;
      #1;
      checkOutput($sformatf("rst beat%0d addr", b), mem_addr_o, 32'h500 + 32'(b * 4));
      checkOutput($sformatf("rst beat%0d beat", b), {30'd0, beat_o}, 32'(b));
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    mem_rdata_i = '0;
    #1;
    checkOutput("rst abort flags", {24'd0, flags()}, {24'd0, F_IDLE});
    checkOutput("rst abort addr", mem_addr_o, 32'd0);
    checkOutput("rst abort beat", {30'd0, beat_o}, 32'd0);
    checkOutput("rst abort rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    ic_req_i = 1'b1;
    #1;
    checkOutput("rst no done", {24'd0, flags()}, {24'd0, F_IDLE});
    @(negedge clk_i);
    ic_req_i = 1'b0;
    #1;
    checkOutput("rst restart flags", {24'd0, flags()}, {24'd0, F_ICRD});
    checkOutput("rst restart addr", mem_addr_o, 32'h500);
    checkOutput("rst restart beat", {30'd0, beat_o}, 32'd0);
    repeat (6) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
